// File: rtl/spi_link_arbiter.sv
// Round-robin arbiter for two command sources sharing one SPI link.
// Serializes 10-bit commands MSB-first and collects 8-bit replies for read commands.
module spi_link_arbiter #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [9:0] cmd0,
    input  logic [9:0] cmd1,
    output logic [1:0] ack,
    output logic [7:0] rdata,
    output logic       rd_err,
    output logic       busy,
    output logic       ss_n,
    output logic       MOSI,
    input  logic       MISO,
    input  logic       valid_MISO,
    input  logic       sready
);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_RD, DONE} state_t;

    state_t     state, state_d;
    logic [9:0] shreg, shreg_d;
    logic [3:0] bit_cnt, bit_cnt_d;
    logic [2:0] rx_cnt, rx_cnt_d;
    logic [7:0] wait_cnt, wait_cnt_d;
    logic [7:0] rdata_sh, rdata_sh_d;
    logic       is_read, is_read_d;
    logic       grant, grant_d;
    logic       last_grant, last_grant_d;
    logic [1:0] ack_d;
    logic [7:0] rdata_d;
    logic       rd_err_d;
    logic       busy_d, ss_n_d, mosi_d;
    logic       sel;
    logic [9:0] sel_cmd;

    always_comb begin
        state_d      = state;
        shreg_d      = shreg;
        bit_cnt_d    = bit_cnt;
        rx_cnt_d     = rx_cnt;
        wait_cnt_d   = wait_cnt;
        rdata_sh_d   = rdata_sh;
        is_read_d    = is_read;
        grant_d      = grant;
        last_grant_d = last_grant;
        ack_d        = '0;
        rdata_d      = rdata;
        rd_err_d     = 1'b0;
        sel          = (req == 2'b11) ? ~last_grant : req[1];
        sel_cmd      = sel ? cmd1 : cmd0;

        case (state)
            IDLE: begin
                if (req != 2'b00 && sready) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    shreg_d      = sel_cmd;
                    is_read_d    = (sel_cmd[9:8] == 2'b11);
                    bit_cnt_d    = '0;
                    rx_cnt_d     = '0;
                    wait_cnt_d   = '0;
                    rdata_sh_d   = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = {shreg[8:0], 1'b0};
                if (bit_cnt == 4'd9) begin
                    if (is_read) begin
                        state_d = WAIT_RD;
                    end else begin
                        state_d = DONE;
                        ack_d   = grant ? 2'b10 : 2'b01;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + 4'd1;
                end
            end
            WAIT_RD: begin
                wait_cnt_d = wait_cnt + 8'd1;
                if (valid_MISO) begin
                    rdata_sh_d = {rdata_sh[6:0], MISO};
                    rx_cnt_d   = rx_cnt + 3'd1;
                end
                // A last bit arriving on the timeout cycle still counts as a good read.
                if (valid_MISO && rx_cnt == 3'd7) begin
                    state_d = DONE;
                    ack_d   = grant ? 2'b10 : 2'b01;
                    rdata_d = {rdata_sh[6:0], MISO};
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    state_d  = DONE;
                    ack_d    = grant ? 2'b10 : 2'b01;
                    rdata_d  = '0;
                    rd_err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        ss_n_d = !(state_d == SHIFT || state_d == WAIT_RD);
        mosi_d = (state_d == SHIFT) ? shreg_d[9] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            rx_cnt     <= '0;
            wait_cnt   <= '0;
            rdata_sh   <= '0;
            is_read    <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            ack        <= '0;
            rdata      <= '0;
            rd_err     <= 1'b0;
            busy       <= 1'b0;
            ss_n       <= 1'b1;
            MOSI       <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bit_cnt    <= bit_cnt_d;
            rx_cnt     <= rx_cnt_d;
            wait_cnt   <= wait_cnt_d;
            rdata_sh   <= rdata_sh_d;
            is_read    <= is_read_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            ack        <= ack_d;
            rdata      <= rdata_d;
            rd_err     <= rd_err_d;
            busy       <= busy_d;
            ss_n       <= ss_n_d;
            MOSI       <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_link_arbiter.sv
// Directed bench for spi_link_arbiter: writes, reads, gapped reads, arbitration,
// stall, timeout and mid-frame reset, with hand-computed expectations.
module tb_spi_link_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [9:0] cmd0 = '0;
    logic [9:0] cmd1 = '0;
    logic [1:0] ack;
    logic [7:0] rdata;
    logic       rd_err;
    logic       busy;
    logic       ss_n;
    logic       MOSI;
    logic       MISO = 1'b0;
    logic       valid_MISO = 1'b0;
    logic       sready = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    spi_link_arbiter #(.TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1),
        .ack(ack), .rdata(rdata), .rd_err(rd_err), .busy(busy),
        .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO), .valid_MISO(valid_MISO),
        .sready(sready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ten SHIFT cycles: ss_n low, MOSI carrying c[9]..c[0], no ack.
    task automatic shift_phase(input logic [9:0] c, input string tag);
        for (int i = 0; i < 10; i++) begin
            step();
            chk({tag, "_ss_n"}, 32'(ss_n), 0);
            chk({tag, "_mosi"}, 32'(MOSI), 32'(c[9 - i]));
            chk({tag, "_ack_shift"}, 32'(ack), 0);
        end
    endtask

    logic [9:0] c;
    logic [7:0] d;

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ss_n", 32'(ss_n), 1);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_rd_err", 32'(rd_err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Read from requester 1, slave returns 8'hC3 with valid_MISO continuous
        c = 10'b11_0000_0000;
        d = 8'hC3;
        cmd1 = c; req = 2'b10; sready = 1'b1;
        shift_phase(c, "rd1");
        for (int j = 0; j < 8; j++) begin
            step();
            chk("rd1_wait_ss_n", 32'(ss_n), 0);
            chk("rd1_wait_mosi", 32'(MOSI), 0);
            chk("rd1_wait_ack", 32'(ack), 0);
            MISO = d[7 - j]; valid_MISO = 1'b1;
        end
        step();
        chk("rd1_ack", 32'(ack), 32'h2);
        chk("rd1_rdata", 32'(rdata), 32'hC3);
        chk("rd1_rd_err", 32'(rd_err), 0);
        chk("rd1_done_ss_n", 32'(ss_n), 1);
        valid_MISO = 1'b0; MISO = 1'b0; req = 2'b00;
        step();
        chk("rd1_idle_busy", 32'(busy), 0);
        chk("rd1_idle_ack", 32'(ack), 0);

        // Write from requester 0; rdata must keep the previous read value
        c = 10'b00_1010_0101;
        cmd0 = c; req = 2'b01;
        valid_MISO = 1'b1; MISO = 1'b1;
        shift_phase(c, "wr0");
        step();
        chk("wr0_ack", 32'(ack), 32'h1);
        chk("wr0_ss_n", 32'(ss_n), 1);
        chk("wr0_busy_done", 32'(busy), 1);
        chk("wr0_rd_err", 32'(rd_err), 0);
        chk("wr0_rdata_kept", 32'(rdata), 32'hC3);
        req = 2'b00; valid_MISO = 1'b0; MISO = 1'b0;
        step();
        chk("wr0_busy_idle", 32'(busy), 0);
        chk("wr0_ack_idle", 32'(ack), 0);

        // Gapped read: valid_MISO toggles 1,0; MISO noise on invalid cycles
        c = 10'h3C5;
        d = 8'h5A;
        cmd0 = c; req = 2'b01;
        shift_phase(c, "gap");
        for (int k = 0; k < 15; k++) begin
            step();
            chk("gap_wait_ack", 32'(ack), 0);
            if (k % 2 == 0) begin
                valid_MISO = 1'b1; MISO = d[7 - k / 2];
            end else begin
                valid_MISO = 1'b0; MISO = ~d[7 - k / 2];
            end
        end
        step();
        chk("gap_ack", 32'(ack), 32'h1);
        chk("gap_rdata", 32'(rdata), 32'h5A);
        chk("gap_rd_err", 32'(rd_err), 0);
        req = 2'b00; valid_MISO = 1'b0; MISO = 1'b0;
        step();
        chk("gap_idle_busy", 32'(busy), 0);

        // Stall with sready low, then a read that times out
        c = 10'h300;
        cmd0 = c; req = 2'b01; sready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("stall_ss_n", 32'(ss_n), 1);
            chk("stall_ack", 32'(ack), 0);
        end
        sready = 1'b1;
        shift_phase(c, "tmo");
        sready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step();
            chk("tmo_wait_ack", 32'(ack), 0);
            MISO = k[0];
        end
        step();
        chk("tmo_ack", 32'(ack), 32'h1);
        chk("tmo_rd_err", 32'(rd_err), 1);
        chk("tmo_rdata", 32'(rdata), 0);
        chk("tmo_ss_n", 32'(ss_n), 1);
        req = 2'b00; sready = 1'b1; MISO = 1'b0;
        step();
        chk("tmo_idle_rd_err", 32'(rd_err), 0);
        chk("tmo_idle_busy", 32'(busy), 0);

        // Arbitration after reset: both held, grants alternate 0,1,0,1 with 2-cycle gap
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmd0 = 10'h055; cmd1 = 10'h0AA; req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            shift_phase((f % 2 == 0) ? 10'h055 : 10'h0AA, "arb");
            step();
            chk("arb_ack", 32'(ack), (f % 2 == 0) ? 32'h1 : 32'h2);
            chk("arb_gap1_ss_n", 32'(ss_n), 1);
            if (f == 3) req = 2'b00;
            step();
            chk("arb_gap2_ss_n", 32'(ss_n), 1);
            chk("arb_gap2_ack", 32'(ack), 0);
        end

        // Mid-frame reset at SHIFT bit 4, then a tie won by requester 0
        cmd0 = 10'h0F0; req = 2'b01;
        for (int i = 0; i < 5; i++) step();
        chk("mid_ss_n_before", 32'(ss_n), 0);
        rst = 1'b1;
        #1;
        chk("mid_ss_n_async", 32'(ss_n), 1);
        chk("mid_busy_async", 32'(busy), 0);
        req = 2'b00;
        step();
        chk("mid_ack_rst", 32'(ack), 0);
        step();
        rst = 1'b0;
        chk("mid_ack_rst2", 32'(ack), 0);
        cmd0 = 10'h099; cmd1 = 10'h166; req = 2'b11;
        shift_phase(10'h099, "post");
        step();
        chk("post_ack", 32'(ack), 32'h1);
        req = 2'b00;
        step();
        chk("post_idle_busy", 32'(busy), 0);
        chk("post_idle_ss_n", 32'(ss_n), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_link_arbiter.md
# spi_link_arbiter

Two-requester controller that owns the single SPI link to the slave and sequences every frame on it. It arbitrates round-robin between requesters and serializes each granted 10-bit command MSB-first on MOSI under ss_n. For read-data commands it collects the slave's 8-bit reply from MISO/valid_MISO. It sits between the system-side command sources and the slave interface signals ss_n, MOSI, MISO, valid_MISO and sready.

## Interface
Parameters:
- TIMEOUT, 32: maximum WAIT_RD cycles before a read is aborted; legal range 8..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-requester request; held high with cmd stable until matching ack.
- cmd0  in  10  requester 0 command: [9:8] type, [7:0] payload.
- cmd1  in  10  requester 1 command: [9:8] type, [7:0] payload.
- ack  out  2  one-cycle completion pulse to the granted requester.
- rdata  out  8  read reply; valid in the ack cycle of a type-2'b11 command.
- rd_err  out  1  high in the ack cycle when a read timed out.
- busy  out  1  high in every state except IDLE.
- ss_n  out  1  active-low slave select.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.
- valid_MISO  in  1  qualifies MISO.
- sready  in  1  slave ready; a new frame starts only when high.

## Operation
- All outputs registered. Reset values: ss_n=1, MOSI=0, ack=0, rdata=0, rd_err=0, busy=0, state=IDLE, last_grant=1.
- IDLE:
  - Frame starts only if req!=0 and sready=1.
  - Single request wins.
  - If both req bits are high, the grant goes to the requester that is not last_grant.
  - On grant: latch cmd into a 10-bit shift register, update last_grant, go to SHIFT.
- SHIFT: ss_n=0, MOSI=shreg[9]; shift left each cycle; bit counter runs 0..9, 10 cycles total. After the 10th bit, go to WAIT_RD if the latched type is 2'b11, else to DONE.
- WAIT_RD:
  - ss_n held 0, MOSI=0.
  - Each cycle with valid_MISO=1, shift MISO into rdata_sh from the LSB, so the first bit received ends as bit 7.
  - After the 8th valid bit, go to DONE.
  - The wait counter increments every cycle. If it reaches TIMEOUT before 8 bits arrive, go to DONE with the error flag set.
- DONE:
  - One cycle: ss_n=1, ack[grant]=1.
  - For reads: rdata=rdata_sh and rd_err=0; on timeout, rdata=8'h00 and rd_err=1.
  - Writes leave rdata unchanged and rd_err=0.
  - Then go to IDLE.
- Latched cmd is used for the whole frame. Changes on cmd, req or sready after grant are ignored until IDLE.
- valid_MISO and MISO are ignored outside WAIT_RD.
- If sready=0 in IDLE, requests stall; no ack is issued.
- rst asserted mid-frame: ss_n goes to 1 immediately (asynchronous); the frame is lost and no ack is issued.

## Timing
- Cycle N: IDLE samples req/sready. N+1..N+10: SHIFT, ss_n=0, MOSI carries cmd[9]..cmd[0].
- Write types (00/01/10): DONE with ack at N+11; IDLE at N+12; earliest next ss_n low at N+13. Minimum ss_n high gap is 2 cycles.
- Read type (11): WAIT_RD from N+11. With valid_MISO continuously high, the 8 bits are sampled N+11..N+18 and ack arrives at N+19.
- Timeout ack at N+11+TIMEOUT.
- ack, rdata and rd_err are valid in the same cycle. ack is never high for both requesters at once.

## Test plan
- Write, requester 0: req=2'b01, cmd0=10'b00_1010_0101, sready=1 -> ss_n low 10 cycles, MOSI=0,0,1,0,1,0,0,1,0,1, ack=2'b01 at N+11, busy low at N+12.
- Read, requester 1: cmd1=10'b11_0000_0000, slave drives 8'hC3 MSB-first with valid_MISO high -> ack=2'b10 at N+19, rdata=8'hC3, rd_err=0.
- Gapped read: valid_MISO toggles 1,0 every cycle -> only valid cycles are sampled, rdata correct, ack at N+26.
- Arbitration: both req held, cmd0=10'h055, cmd1=10'h0AA, after reset -> grant order 0,1,0,1; ss_n gap exactly 2 cycles between frames.
- Stall and timeout: sready=0 with req=2'b01 for 20 cycles -> ss_n stays 1, no ack. Then sready=1 with a read command and no valid_MISO -> ack at N+43, rd_err=1, rdata=8'h00.
- Reset mid-frame: assert rst at SHIFT bit 4 -> ss_n=1 within the same cycle, no ack. After release, a fresh request completes normally with requester 0 winning a tie.
